// File: rtl/etapa_if.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a req/ack handshake, applies next-PC selection, and feeds opcode/funct to control.
module etapa_if #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  SEL_DIR,
  input  logic        resetIF,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        valid_id,
  output logic        o_dbg_state
);

  // Handshake: imem_req high means imem_addr is valid and held stable until a
  // cycle with imem_ack high; imem_rdata is consumed in that same cycle.
  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_hold_buf;
  logic        r_redir_pend;
  logic [31:0] r_redir_tgt;

  logic        w_req;
  logic        w_ack;
  logic        w_redir;
  logic [31:0] w_pc4;
  logic [31:0] w_target;

  // r_run keeps req low until the first edge after reset release.
  assign w_req   = r_run && (r_state == S_FETCH);
  assign w_ack   = w_req && imem_ack;
  assign w_redir = !stall && ((SEL_DIR == 2'b01) || (SEL_DIR == 2'b10));
  assign w_pc4   = r_pc + 32'd4;

  always_comb begin
    w_target = w_pc4;
    case (SEL_DIR)
      2'b01:   w_target = {r_pc4[31:28], r_instr[25:0], 2'b00};
      2'b10:   w_target = {jr_target[31:2], 2'b00};
      default: w_target = w_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (w_ack && stall && !r_redir_pend) w_state_nxt = S_HOLD;
      S_HOLD:  if (!stall) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_pc         <= PC_RESET;
      r_instr      <= NOP;
      r_pc4        <= 32'd0;
      r_valid      <= 1'b0;
      r_hold_buf   <= 32'd0;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= 32'd0;
    end else begin
      r_run <= 1'b1;
      if (w_ack) begin
        if (r_redir_pend) begin
          // Word belongs to the abandoned path; a fresh redirect wins over the saved one.
          r_pc         <= w_redir ? w_target : r_redir_tgt;
          r_redir_pend <= 1'b0;
          if (!stall) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
          end
        end else if (stall) begin
          r_hold_buf <= imem_rdata;
        end else if (w_redir) begin
          r_pc    <= w_target;
          r_instr <= NOP;
          r_valid <= 1'b0;
        end else begin
          r_instr <= imem_rdata;
          r_pc4   <= w_pc4;
          r_valid <= 1'b1;
          r_pc    <= w_pc4;
        end
      end else if (w_req && w_redir) begin
        // Address must not move mid-request, so remember where to go.
        r_redir_pend <= 1'b1;
        r_redir_tgt  <= w_target;
      end else if ((r_state == S_HOLD) && !stall) begin
        if (w_redir) begin
          r_pc    <= w_target;
          r_instr <= NOP;
          r_valid <= 1'b0;
        end else begin
          r_instr <= r_hold_buf;
          r_pc4   <= w_pc4;
          r_valid <= 1'b1;
          r_pc    <= w_pc4;
        end
      end
      if (resetIF) begin
        r_instr <= NOP;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_id    = r_instr;
  assign pc4_id      = r_pc4;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign valid_id    = r_valid;
  assign o_dbg_state = r_state;

endmodule
